// File: rtl/tlb_pkg.sv
// Field widths and page record shared by the TLB and its users.
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } page_t;

endpackage

// File: rtl/tlb_match_enc.sv
// Match vector to {found, lowest matching index}; lowest index wins on multi-hit.
module tlb_match_enc #(
  parameter  int N  = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_match,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  always_comb begin
    o_found = |i_match;
    o_index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_match[i]) o_index = IW'(i);
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully associative dual-page TLB: two combinational search ports, one write port, one read port.
module tlb
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,

  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,

  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,

  input  logic [IDXW-1:0]   r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1
);

  // Flop arrays rather than RAM: every entry is compared in parallel each cycle.
  logic [VPN2_W-1:0] r_ent_vpn2 [TLBNUM];
  logic [ASID_W-1:0] r_ent_asid [TLBNUM];
  logic              r_ent_g    [TLBNUM];
  page_t             r_ent_page [TLBNUM][2];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        r_ent_vpn2[i]    <= '0;
        r_ent_asid[i]    <= '0;
        r_ent_g[i]       <= 1'b0;
        r_ent_page[i][0] <= '0;
        r_ent_page[i][1] <= '0;
      end
    end else if (we) begin
      r_ent_vpn2[w_index]    <= w_vpn2;
      r_ent_asid[w_index]    <= w_asid;
      r_ent_g[w_index]       <= w_g;
      r_ent_page[w_index][0] <= {w_pfn0, w_c0, w_d0, w_v0};
      r_ent_page[w_index][1] <= {w_pfn1, w_c1, w_d1, w_v1};
    end
  end

  logic [VPN2_W-1:0] w_s_vpn2  [2];
  logic              w_s_odd   [2];
  logic [ASID_W-1:0] w_s_asid  [2];
  logic              w_s_found [2];
  logic [IDXW-1:0]   w_s_index [2];
  page_t             w_s_page  [2];

  assign w_s_vpn2[0] = s0_vpn2;
  assign w_s_odd[0]  = s0_odd_page;
  assign w_s_asid[0] = s0_asid;
  assign w_s_vpn2[1] = s1_vpn2;
  assign w_s_odd[1]  = s1_odd_page;
  assign w_s_asid[1] = s1_asid;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [TLBNUM-1:0] w_match;

    for (genvar gj = 0; gj < TLBNUM; gj++) begin : g_cmp
      assign w_match[gj] = (r_ent_vpn2[gj] == w_s_vpn2[gi]) &&
                           (r_ent_g[gj] || (r_ent_asid[gj] == w_s_asid[gi]));
    end

    tlb_match_enc #(.N(TLBNUM)) u_enc (
      .i_match (w_match),
      .o_found (w_s_found[gi]),
      .o_index (w_s_index[gi])
    );

    // A miss forces the whole result to zero rather than exposing entry 0's page.
    assign w_s_page[gi] = w_s_found[gi] ? r_ent_page[w_s_index[gi]][w_s_odd[gi]] : '0;
  end

  assign s0_found = w_s_found[0];
  assign s0_index = w_s_index[0];
  assign {s0_pfn, s0_c, s0_d, s0_v} = w_s_page[0];
  assign s1_found = w_s_found[1];
  assign s1_index = w_s_index[1];
  assign {s1_pfn, s1_c, s1_d, s1_v} = w_s_page[1];

  assign r_vpn2 = r_ent_vpn2[r_index];
  assign r_asid = r_ent_asid[r_index];
  assign r_g    = r_ent_g[r_index];
  assign {r_pfn0, r_c0, r_d0, r_v0} = r_ent_page[r_index][0];
  assign {r_pfn1, r_c1, r_d1, r_v1} = r_ent_page[r_index][1];

endmodule
